// File: rtl/alib_seq_pkg.sv
// Shared types and constants for the ALFA point-cloud conversion sequencer.
// Holds the state encoding, the ID/point widths, the status word layout
// and the result FIFO entry format.
package alib_seq_pkg;

    localparam int ID_W = 19;
    localparam int PT_W = 16;

    localparam int STATUS_STATE_LSB = 30;
    localparam int STATUS_COUNT_LSB = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [PT_W-1:0] tag;
        logic [PT_W-1:0] x;
        logic [PT_W-1:0] y;
        logic [PT_W-1:0] z;
    } fifo_entry_t;

    // Status word: {state[1:0], 11'b0, fifo_count[3:0], 15'b0}
    function automatic logic [31:0] make_status(input seq_state_t st, input logic [3:0] cnt);
        logic [31:0] s;
        s = '0;
        s[STATUS_STATE_LSB +: 2] = st;
        s[STATUS_COUNT_LSB +: 4] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/alib_seq_fifo.sv
// Synchronous FIFO for converted points. Pointers wrap naturally modulo
// DEPTH (power of two); occupancy is tracked in a separate counter so
// full and empty never need a pointer-extension bit.
module alib_seq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is allowed when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array; written only, never reset.
    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alib_conv_point_sequencer.sv
// Sequencer driving a fixed-latency spherical-to-Cartesian converter from
// the ALFA extension interface: reads points 0..PCSize-1, launches them into
// the converter, buffers results in a FIFO and writes them back in order.
// Optional build macro ALIB_SEQ_RANGE_FILTER_EN: points with radius below
// MIN_RADIUS are read and counted but neither launched nor written.
//
// state | meaning
// IDLE  | waiting for EXT_enable; size sampled on start
// RUN   | issuing reads while credits remain
// DRAIN | all reads accepted, waiting for the last write
// DONE  | EXT_doneProcessing high until EXT_enable drops
module alib_conv_point_sequencer
    import alib_seq_pkg::*;
#(
    parameter int          CONV_LATENCY = 4,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] MIN_RADIUS   = 16'd1
) (
    input  logic            i_SYSTEM_clk,
    input  logic            i_SYSTEM_rst,
    input  logic            EXT_enable,
    input  logic [ID_W-1:0] EXT_PCSize,
    input  logic            EXT_readValid,
    output logic            EXT_readReady,
    output logic [ID_W-1:0] EXT_readID,
    input  logic [PT_W-1:0] EXT_readCustomField,
    input  logic [PT_W-1:0] EXT_pointAngleH,
    input  logic [PT_W-1:0] EXT_pointAngleV,
    input  logic [PT_W-1:0] EXT_pointRadius,
    output logic            EXT_writeValid,
    input  logic            EXT_writeReady,
    output logic [ID_W-1:0] EXT_writeID,
    output logic [PT_W-1:0] EXT_writeCustomField,
    output logic [PT_W-1:0] EXT_pointX,
    output logic [PT_W-1:0] EXT_pointY,
    output logic [PT_W-1:0] EXT_pointZ,
    output logic            EXT_doneProcessing,
    output logic [31:0]     EXT_status,
    output logic [PT_W-1:0] o_conv_angle_h,
    output logic [PT_W-1:0] o_conv_angle_v,
    output logic [PT_W-1:0] o_conv_radius,
    input  logic [PT_W-1:0] i_conv_x,
    input  logic [PT_W-1:0] i_conv_y,
    input  logic [PT_W-1:0] i_conv_z
);

    // One stage beyond the converter latency so the tail lines up with the
    // converter outputs of the same point.
    localparam int STAGES = CONV_LATENCY + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    seq_state_t       state;
    seq_state_t       state_next;
    logic [ID_W-1:0]  size;
    logic [ID_W-1:0]  rd_cnt;
    logic [ID_W-1:0]  rd_cnt_next;
    logic [ID_W-1:0]  wr_cnt;
    logic [ID_W-1:0]  wr_cnt_next;
    logic             start;
    logic             rd_accept;
    logic             credit_ok;
    int               inflight;
    logic             pt_skip;

    logic [STAGES-1:0] sr_valid;
    logic [STAGES-1:0] sr_skip;
    logic [ID_W-1:0]   sr_id  [STAGES];
    logic [PT_W-1:0]   sr_tag [STAGES];
    logic              tail_valid;
    logic              tail_skip;
    logic              bypass;

    fifo_entry_t       fifo_wdata;
    fifo_entry_t       fifo_rdata;
    logic              fifo_push;
    logic              fifo_pop;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

`ifdef ALIB_SEQ_RANGE_FILTER_EN
    assign pt_skip = (EXT_pointRadius < MIN_RADIUS);
`else
    logic unused_min_radius;
    assign pt_skip           = 1'b0;
    assign unused_min_radius = ^MIN_RADIUS;
`endif

    // Credits cover both buffered results and points still in the converter,
    // so every in-flight point is guaranteed a FIFO slot on arrival.
    always_comb begin
        inflight  = $countones(sr_valid);
        credit_ok = (int'(fifo_count) + inflight) < FIFO_DEPTH;
    end

    assign EXT_readReady = (state == ST_RUN) && credit_ok;
    assign EXT_readID    = rd_cnt;
    assign rd_accept     = EXT_readReady && EXT_readValid;
    assign start         = (state == ST_IDLE) && EXT_enable && (EXT_PCSize != '0);

    assign tail_valid = sr_valid[STAGES-1];
    assign tail_skip  = sr_skip[STAGES-1];
    assign fifo_push  = tail_valid && !tail_skip;
    assign bypass     = tail_valid && tail_skip;
    assign fifo_pop   = EXT_writeValid && EXT_writeReady;

    assign rd_cnt_next = rd_cnt + ID_W'(rd_accept);
    assign wr_cnt_next = wr_cnt + ID_W'(fifo_pop) + ID_W'(bypass);

    // State register.
    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; enable is ignored once a run has started.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (EXT_enable) begin
                    state_next = (EXT_PCSize == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (rd_cnt_next == size) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wr_cnt_next == size) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!EXT_enable) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Size latch and read/write point counters.
    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            size   <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (start) begin
            size   <= EXT_PCSize;
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            rd_cnt <= rd_cnt_next;
            wr_cnt <= wr_cnt_next;
        end
    end

    // Converter launch registers; filtered points leave them untouched.
    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            o_conv_angle_h <= '0;
            o_conv_angle_v <= '0;
            o_conv_radius  <= '0;
        end else if (rd_accept && !pt_skip) begin
            o_conv_angle_h <= EXT_pointAngleH;
            o_conv_angle_v <= EXT_pointAngleV;
            o_conv_radius  <= EXT_pointRadius;
        end
    end

    // Side-band shift register tracking ID/tag alongside the converter pipe.
    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            sr_valid <= '0;
            sr_skip  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                sr_id[i]  <= '0;
                sr_tag[i] <= '0;
            end
        end else begin
            sr_valid <= {sr_valid[STAGES-2:0], rd_accept};
            sr_skip  <= {sr_skip[STAGES-2:0], rd_accept && pt_skip};
            sr_id[0]  <= rd_cnt;
            sr_tag[0] <= EXT_readCustomField;
            for (int i = 1; i < STAGES; i++) begin
                sr_id[i]  <= sr_id[i-1];
                sr_tag[i] <= sr_tag[i-1];
            end
        end
    end

    // Capture entry formed from the tail tag and the live converter outputs.
    always_comb begin
        fifo_wdata     = '0;
        fifo_wdata.id  = sr_id[STAGES-1];
        fifo_wdata.tag = sr_tag[STAGES-1];
        fifo_wdata.x   = i_conv_x;
        fifo_wdata.y   = i_conv_y;
        fifo_wdata.z   = i_conv_z;
    end

    alib_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clk_sys (i_SYSTEM_clk),
        .rst_n   (i_SYSTEM_rst),
        .push    (fifo_push),
        .wdata   (fifo_wdata),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Write data comes straight from the FIFO head, forced to zero when idle.
    assign EXT_writeValid       = !fifo_empty;
    assign EXT_writeID          = EXT_writeValid ? fifo_rdata.id  : '0;
    assign EXT_writeCustomField = EXT_writeValid ? fifo_rdata.tag : '0;
    assign EXT_pointX           = EXT_writeValid ? fifo_rdata.x   : '0;
    assign EXT_pointY           = EXT_writeValid ? fifo_rdata.y   : '0;
    assign EXT_pointZ           = EXT_writeValid ? fifo_rdata.z   : '0;

    assign EXT_doneProcessing = (state == ST_DONE);
    assign EXT_status         = make_status(state, 4'(fifo_count));

    fifo_no_overflow: assert property (@(posedge i_SYSTEM_clk) disable iff (!i_SYSTEM_rst)
        !(fifo_push && fifo_full));

endmodule

// File: tb/tb_alib_conv_point_sequencer.sv
// Directed bench for alib_conv_point_sequencer with a 4-cycle converter
// model and an in-order write scoreboard.
module tb_alib_conv_point_sequencer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [18:0] EXT_PCSize;
    logic        rv;
    logic        wr;
    logic        EXT_readReady;
    logic [18:0] EXT_readID;
    logic [15:0] EXT_readCustomField;
    logic [15:0] EXT_pointAngleH;
    logic [15:0] EXT_pointAngleV;
    logic [15:0] EXT_pointRadius;
    logic        EXT_writeValid;
    logic [18:0] EXT_writeID;
    logic [15:0] EXT_writeCustomField;
    logic [15:0] EXT_pointX;
    logic [15:0] EXT_pointY;
    logic [15:0] EXT_pointZ;
    logic        EXT_doneProcessing;
    logic [31:0] EXT_status;
    logic [15:0] o_conv_angle_h;
    logic [15:0] o_conv_angle_v;
    logic [15:0] o_conv_radius;
    logic [15:0] i_conv_x;
    logic [15:0] i_conv_y;
    logic [15:0] i_conv_z;

    logic        rnd_mode;
    logic        radius_mode;
    logic        filter_on;
    logic [47:0] cv_pipe [4];

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_acc, n_wr, first_acc, last_acc, first_wr, last_wr, done_cyc;
    int rr_pulses, wv_pulses, max_cnt;
    logic        done_seen;
    logic [18:0] exp_rid, exp_wid, last_wid, first_wid;

    always #5 clk = ~clk;

    alib_conv_point_sequencer dut (
        .i_SYSTEM_clk         (clk),
        .i_SYSTEM_rst         (rst),
        .EXT_enable           (enable),
        .EXT_PCSize           (EXT_PCSize),
        .EXT_readValid        (rv),
        .EXT_readReady        (EXT_readReady),
        .EXT_readID           (EXT_readID),
        .EXT_readCustomField  (EXT_readCustomField),
        .EXT_pointAngleH      (EXT_pointAngleH),
        .EXT_pointAngleV      (EXT_pointAngleV),
        .EXT_pointRadius      (EXT_pointRadius),
        .EXT_writeValid       (EXT_writeValid),
        .EXT_writeReady       (wr),
        .EXT_writeID          (EXT_writeID),
        .EXT_writeCustomField (EXT_writeCustomField),
        .EXT_pointX           (EXT_pointX),
        .EXT_pointY           (EXT_pointY),
        .EXT_pointZ           (EXT_pointZ),
        .EXT_doneProcessing   (EXT_doneProcessing),
        .EXT_status           (EXT_status),
        .o_conv_angle_h       (o_conv_angle_h),
        .o_conv_angle_v       (o_conv_angle_v),
        .o_conv_radius        (o_conv_radius),
        .i_conv_x             (i_conv_x),
        .i_conv_y             (i_conv_y),
        .i_conv_z             (i_conv_z)
    );

    function automatic logic [15:0] h_of(input logic [18:0] id);
        logic [15:0] t;
        t = id[15:0];
        return t * 16'd3 + 16'd7;
    endfunction

    function automatic logic [15:0] v_of(input logic [18:0] id);
        logic [15:0] t;
        t = id[15:0];
        return t * 16'd5 + 16'd1;
    endfunction

    function automatic logic [15:0] rad_of(input logic [18:0] id, input logic mode);
        logic [15:0] tbl [4];
        tbl = '{16'd0, 16'd5, 16'd0, 16'd9};
        if (mode) return tbl[id[1:0]];
        return id[15:0] + 16'd100;
    endfunction

    function automatic logic [15:0] tag_of(input logic [18:0] id);
        return id[15:0] ^ 16'hA5A5;
    endfunction

    function automatic logic [47:0] conv_f(input logic [15:0] h, input logic [15:0] v, input logic [15:0] r);
        return {r + h, r - v, h ^ v};
    endfunction

    assign EXT_pointAngleH     = h_of(EXT_readID);
    assign EXT_pointAngleV     = v_of(EXT_readID);
    assign EXT_pointRadius     = rad_of(EXT_readID, radius_mode);
    assign EXT_readCustomField = tag_of(EXT_readID);

    // Converter model: fixed 4-cycle pipeline after the registered launch.
    always @(posedge clk) begin
        cv_pipe[0] <= conv_f(o_conv_angle_h, o_conv_angle_v, o_conv_radius);
        for (int i = 1; i < 4; i++) cv_pipe[i] <= cv_pipe[i-1];
    end
    assign {i_conv_x, i_conv_y, i_conv_z} = cv_pipe[3];

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_clear();
        n_acc = 0; n_wr = 0; first_acc = 0; last_acc = 0; first_wr = 0; last_wr = 0;
        done_cyc = 0; done_seen = 1'b0; rr_pulses = 0; wv_pulses = 0; max_cnt = 0;
        exp_rid = '0; exp_wid = '0; last_wid = '0; first_wid = '0;
    endtask

    // Per-cycle observation, taken mid-cycle on the falling edge.
    task automatic sample();
        logic [47:0] e;
        cyc++;
        if (EXT_readReady) rr_pulses++;
        if (EXT_writeValid) wv_pulses++;
        if (int'(EXT_status[18:15]) > max_cnt) max_cnt = int'(EXT_status[18:15]);
        if (EXT_readReady && rv) begin
            chk_val("rd_id", EXT_readID, exp_rid);
            if (n_acc == 0) first_acc = cyc;
            last_acc = cyc;
            n_acc++;
            exp_rid++;
        end
        if (EXT_writeValid && wr) begin
            while (filter_on && rad_of(exp_wid, radius_mode) < 16'd1) exp_wid++;
            e = conv_f(h_of(exp_wid), v_of(exp_wid), rad_of(exp_wid, radius_mode));
            chk_val("wr_id", EXT_writeID, exp_wid);
            chk_val("wr_tag", EXT_writeCustomField, tag_of(exp_wid));
            chk_val("wr_x", EXT_pointX, e[47:32]);
            chk_val("wr_y", EXT_pointY, e[31:16]);
            chk_val("wr_z", EXT_pointZ, e[15:0]);
            if (n_wr == 0) begin
                first_wr  = cyc;
                first_wid = EXT_writeID;
            end
            last_wr  = cyc;
            last_wid = EXT_writeID;
            n_wr++;
            exp_wid++;
        end
        if (EXT_doneProcessing && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst) sample();
        @(posedge clk);
        #1;
        if (rnd_mode) begin
            rv = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k;
        k = 0;
        while (!EXT_doneProcessing && k < budget) begin
            tick();
            k++;
        end
        chk_val(tag, EXT_doneProcessing, 1'b1);
        tick();
    endtask

    task automatic check_zero(input string tag);
        chk_val({tag, "_rready"}, EXT_readReady, 0);
        chk_val({tag, "_rid"}, EXT_readID, 0);
        chk_val({tag, "_wvalid"}, EXT_writeValid, 0);
        chk_val({tag, "_wid"}, EXT_writeID, 0);
        chk_val({tag, "_wtag"}, EXT_writeCustomField, 0);
        chk_val({tag, "_xyz"}, {EXT_pointX, EXT_pointY, EXT_pointZ}, 0);
        chk_val({tag, "_done"}, EXT_doneProcessing, 0);
        chk_val({tag, "_status"}, EXT_status, 0);
        chk_val({tag, "_conv"}, {o_conv_angle_h, o_conv_angle_v, o_conv_radius}, 0);
    endtask

    initial begin
        int k;
        rst = 1'b1; enable = 1'b0; rv = 1'b0; wr = 1'b0; EXT_PCSize = '0;
        rnd_mode = 1'b0; radius_mode = 1'b0; filter_on = 1'b0;
        sb_clear();
        #1 rst = 1'b0;
        #2 check_zero("por");
        @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // Streaming run of 5 points at full rate.
        sb_clear();
        EXT_PCSize = 19'd5; rv = 1'b1; wr = 1'b1; enable = 1'b1;
        wait_done(100, "t1_done");
        chk_val("t1_acc", n_acc, 5);
        chk_val("t1_acc_span", last_acc - first_acc, 4);
        chk_val("t1_wr", n_wr, 5);
        chk_val("t1_wr_span", last_wr - first_wr, 4);
        chk_val("t1_latency", first_wr - first_acc, 6);
        chk_val("t1_done_gap", done_cyc - last_wr, 1);
        enable = 1'b0;
        tick(); tick();
        chk_val("t1_idle_done", EXT_doneProcessing, 0);
        chk_val("t1_idle_status", EXT_status, 0);

        // Write back-pressure: reads stop at FIFO depth.
        sb_clear();
        EXT_PCSize = 19'd20; rv = 1'b1; wr = 1'b0; enable = 1'b1;
        repeat (30) tick();
        chk_val("t2_acc_stall", n_acc, DEPTH);
        chk_val("t2_rready", EXT_readReady, 0);
        chk_val("t2_status", EXT_status, 32'h4004_0000);
        wr = 1'b1;
        wait_done(300, "t2_done");
        chk_val("t2_wr", n_wr, 20);
        chk_val("t2_last_id", last_wid, 19);
        enable = 1'b0;
        tick(); tick();

        // Empty cloud.
        sb_clear();
        EXT_PCSize = '0; rv = 1'b1; wr = 1'b1; enable = 1'b1;
        tick();
        chk_val("t3_done_next", EXT_doneProcessing, 1);
        tick(); tick(); tick();
        chk_val("t3_no_rready", rr_pulses, 0);
        chk_val("t3_no_wvalid", wv_pulses, 0);
        enable = 1'b0;
        tick();
        chk_val("t3_idle_done", EXT_doneProcessing, 0);
        chk_val("t3_idle_status", EXT_status, 0);

        // Reset in the middle of a run.
        sb_clear();
        EXT_PCSize = 19'd10; rv = 1'b1; wr = 1'b0; enable = 1'b1;
        k = 0;
        while (n_acc < 3 && k < 100) begin tick(); k++; end
        rv = 1'b0;
        k = 0;
        while (!EXT_writeValid && k < 100) begin tick(); k++; end
        wr = 1'b1;
        tick();
        wr = 1'b0;
        chk_val("t4_pre_rid", EXT_readID, 3);
        chk_val("t4_pre_wr", n_wr, 1);
        #2 rst = 1'b0;
        #1 check_zero("t4_rst");
        enable = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        sb_clear();
        rv = 1'b1; wr = 1'b1; enable = 1'b1;
        wait_done(200, "t4_done");
        chk_val("t4_first_wid", first_wid, 0);
        chk_val("t4_wr", n_wr, 10);
        enable = 1'b0;
        tick(); tick();

        // Random handshakes on both sides.
        sb_clear();
        EXT_PCSize = 19'd64; rnd_mode = 1'b1; enable = 1'b1;
        wait_done(4000, "t5_done");
        rnd_mode = 1'b0; rv = 1'b1; wr = 1'b1;
        chk_val("t5_acc", n_acc, 64);
        chk_val("t5_wr", n_wr, 64);
        chk_val("t5_fifo_bound", max_cnt <= DEPTH, 1);
        enable = 1'b0;
        tick(); tick();

`ifdef ALIB_SEQ_RANGE_FILTER_EN
        // Radius filter: zero-radius points are dropped.
        sb_clear();
        radius_mode = 1'b1; filter_on = 1'b1;
        EXT_PCSize = 19'd4; rv = 1'b1; wr = 1'b1; enable = 1'b1;
        wait_done(100, "t6_done");
        chk_val("t6_acc", n_acc, 4);
        chk_val("t6_wr", n_wr, 2);
        chk_val("t6_first_id", first_wid, 1);
        chk_val("t6_last_id", last_wid, 3);
        chk_val("t6_done_gap", done_cyc - last_wr, 1);
        enable = 1'b0;
        tick(); tick();
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/alib_conv_point_sequencer.md
Name: alib_conv_point_sequencer

Overview:
- Sequences a fixed-latency spherical-to-Cartesian converter against the ALFA extension interface.
- Issues point reads 0..PCSize-1, launches each point into the converter pipeline, and buffers converted X/Y/Z in a small result FIFO.
- Writes results back in order, with credit-based flow control, and raises done when the whole point cloud has been written.

Parameters:
- CONV_LATENCY, 4: cycles from converter launch to valid X/Y/Z at its outputs (fixed, no stall).
- FIFO_DEPTH, 8: result FIFO entries; power of two, ≥ CONV_LATENCY+1.
- MIN_RADIUS, 16'd1: radius threshold used only by the optional filter.

Ports:
- i_SYSTEM_clk  in  1  sole clock, rising edge.
- i_SYSTEM_rst  in  1  reset, asynchronous assert, active-low.
- EXT_enable  in  1  start/hold; level-sensitive.
- EXT_PCSize  in  19  points in the cloud; sampled on start.
- EXT_readValid  in  1  read data valid for EXT_readID.
- EXT_readReady  out  1  read request.
- EXT_readID  out  19  point index requested.
- EXT_readCustomField  in  16  per-point tag.
- EXT_pointAngleH/V, EXT_pointRadius  in  16 each  spherical point.
- EXT_writeValid  out  1  result valid.
- EXT_writeReady  in  1  sink accepts.
- EXT_writeID  out  19  point index of result.
- EXT_writeCustomField  out  16  tag carried with point.
- EXT_pointX/Y/Z  out  16 each  Cartesian result (cm).
- EXT_doneProcessing  out  1  cloud complete.
- EXT_status  out  32  {state[1:0], 11'b0, fifo_count[3:0], 15'b0}.
- o_conv_angle_h, o_conv_angle_v, o_conv_radius  out  16 each  converter inputs, registered.
- i_conv_x, i_conv_y, i_conv_z  in  16 each  converter outputs.

Behaviour:
- Reset: every output 0; state IDLE; counters, FIFO and shift register cleared. Reset mid-run aborts with no flush.
- States:
  - IDLE→RUN: EXT_enable=1 and EXT_PCSize≠0. Latch the size; rd_cnt=wr_cnt=0.
  - EXT_PCSize=0 with enable: IDLE→DONE directly.
  - RUN→DRAIN: last read accepted (rd_cnt==size).
  - DRAIN→DONE: wr_cnt==size.
  - DONE: EXT_doneProcessing=1; →IDLE when EXT_enable=0.
  - EXT_enable dropping in RUN/DRAIN: no effect; the run completes.
- Read side:
  - EXT_readReady=1 in RUN when credits>0, where credits = FIFO_DEPTH − fifo_count − inflight.
  - EXT_readID=rd_cnt.
  - Accept = readReady & readValid; rd_cnt increments on accept.
- Launch:
  - On accept, register the angles/radius onto o_conv_*.
  - Push {valid, rd_cnt, customField} into a CONV_LATENCY+1 stage shift register.
  - inflight = popcount of valid bits.
- Capture: when the shift register tail is valid, push {id, tag, i_conv_x/y/z} into the FIFO. Overflow is impossible by the credit rule; assert in simulation.
- Write side:
  - EXT_writeValid = FIFO non-empty; outputs driven from the FIFO head.
  - Pop on writeValid & writeReady; wr_cnt increments.
  - Write data is held stable while writeValid=1 and writeReady=0.
- Simultaneous push and pop: count unchanged, both succeed.
- Full FIFO: no new reads are issued; in-flight points always have space.
- Pointer wrap: natural modulo FIFO_DEPTH; count is kept separately.
- Throughput: 1 point/cycle when readValid and writeReady are held high.
- Minimum latency from read accept to writeValid: CONV_LATENCY+2 cycles.

Optional Feature:
- ALIB_SEQ_RANGE_FILTER_EN defined:
  - Points with radius < MIN_RADIUS are still read and counted, but are not launched or written.
  - wr_cnt still advances for them, via the FIFO bypass counter on capture.
  - EXT_writeID therefore has gaps.
- Undefined: every point is written; no comparator is present.

Decomposition:
- Package alib_seq_pkg holds:
  - the state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - the ID width of 19 and point width of 16;
  - the status field offsets;
  - the FIFO entry struct {id, tag, x, y, z}.
- Sub-module alib_seq_fifo: synchronous FIFO, parameterised depth and width, exposing count, full and empty.

Test Plan:
- PCSize=5, readValid and writeReady always 1 → reads 0..4 on consecutive cycles; writes 0..4 in order; X/Y/Z match the converter model; done asserted 1 cycle after the 5th write.
- PCSize=20, writeReady=0 for 30 cycles then 1 → readReady stops after exactly FIFO_DEPTH=8 accepts; no loss; IDs 0..19 written in order.
- PCSize=0, enable=1 → DONE next cycle; no readReady or writeValid pulses; enable=0 returns to IDLE.
- Reset asserted (low) mid-run, at rd_cnt=3 with wr_cnt=1 → all outputs 0 asynchronously; after release and enable, the run restarts at readID 0.
- Random readValid/writeReady (50%), PCSize=64, customField=id^16'hA5A5 → every writeCustomField matches its writeID; FIFO never overflows.
- ALIB_SEQ_RANGE_FILTER_EN, PCSize=4, radii {0,5,0,9} → only writeIDs 1 and 3 are emitted; done asserts after the ID-3 write.
